data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, data array depth in 32-bit words; SHALL be a power of two, 16..65536.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port MEM_mem_addr  input  32  byte address from the processor MEM stage.
REQ-005 Port MEM_mem_cmd  input  2  command: `BUS_NONE, `BUS_LOAD or `BUS_STORE; any other code SHALL be treated as `BUS_NONE.
REQ-006 Port MEM_mem_din  input  32  store data.
REQ-007 Port DM_mem_dout  output  32  load data, valid in the same cycle as the `BUS_LOAD command.
REQ-008 Port DM_err  output  1  high in any cycle with a load or store whose address is misaligned or out of range.
REQ-009 Ports DM_ld_cnt, DM_st_cnt, DM_fwd_cnt  output  32 each  statistics counters (REQ-024).

Function
REQ-010 Word index SHALL be MEM_mem_addr[log2(DEPTH_WORDS)+1:2].
REQ-011 An access SHALL be illegal if MEM_mem_addr[1:0]!=0 or MEM_mem_addr[31:log2(DEPTH_WORDS)+2]!=0.
REQ-012 Array SHALL be single-port: per cycle at most one operation, either a combinational read or a clocked write.
REQ-013 Store buffer SHALL hold one entry (sb_vld, sb_idx, sb_data); stores SHALL never stall, and the block SHALL have no back-pressure output.
REQ-014 Legal store with sb_vld=0 SHALL capture the entry at the clock edge, with no array write.
REQ-015 Legal store with sb_vld=1 and sb_idx==index SHALL overwrite sb_data only.
REQ-016 Legal store with sb_vld=1 and sb_idx!=index SHALL write the old entry to the array and capture the new entry on the same edge.
REQ-017 A cycle with sb_vld=1 and no legal load or store SHALL drain the entry to the array and clear sb_vld.
REQ-018 Legal load with sb_vld=1 and sb_idx==index SHALL return sb_data (forward); otherwise it SHALL return the array word; the buffer SHALL hold.
REQ-019 Load latency SHALL be zero cycles: DM_mem_dout SHALL be combinational from address, buffer and array.
REQ-020 Illegal load SHALL return 32'h0; illegal store SHALL not modify the buffer or the array; DM_err SHALL be combinational and high only in that cycle.
REQ-021 DM_mem_dout SHALL be 32'h0 for `BUS_NONE and `BUS_STORE cycles.
REQ-022 A load to the word stored in the previous cycle SHALL return the stored data, whether it is still buffered or already drained.

Reset
REQ-023 rst_n low SHALL asynchronously clear sb_vld, sb_idx, sb_data and all counters; DM_mem_dout and DM_err SHALL be 0 while rst_n is low; array contents SHALL not be reset; a buffered store pending at reset SHALL be lost.

Configuration
REQ-024 With DMEM_STATS_EN defined, DM_ld_cnt, DM_st_cnt and DM_fwd_cnt SHALL count legal loads, legal stores and forwarded loads, each saturating at 32'hFFFF_FFFF.
REQ-025 Without DMEM_STATS_EN, the three ports SHALL remain present, tied to 32'h0, and no counter flops SHALL be inferred.

Structure
REQ-026 `BUS_NONE, `BUS_LOAD, `BUS_STORE and `FALSE/`TRUE SHALL come from the shared sys_defs.vh; no local redefinition is allowed.
REQ-027 The store buffer and its drain/forward logic SHALL be a sub-module dmem_store_buf; the array, address checking and counters SHALL stay in data_mem.

Verification
REQ-028 Store 0x0000_0040 <- 32'hDEAD_BEEF, then load 0x40 in the next cycle -> DM_mem_dout = 32'hDEAD_BEEF (forwarded), DM_fwd_cnt = 1.
REQ-029 Store 0x40 <- 32'h1; store 0x44 <- 32'h2; two `BUS_NONE cycles; load 0x40 then 0x44 -> returns 32'h1 then 32'h2, sb_vld = 0 before the loads.
REQ-030 Back-to-back stores to 0x80 (32'hA, then 32'hB), then load 0x80 -> returns 32'hB, with no array write for 32'hA.
REQ-031 Load 0x42 and store to 0x0000_1000 (with DEPTH_WORDS = 1024) -> DM_err = 1 in each cycle, dout = 0, array and buffer unchanged.
REQ-032 Store 0x40 <- 32'h5, drop rst_n in the next cycle, release it, then load 0x40 -> buffer lost, returns the pre-store array value; counters read 0.
REQ-033 Build without DMEM_STATS_EN, run 100 loads -> all counter ports = 0; build with DMEM_STATS_EN -> DM_ld_cnt = 100.

Source files
------------

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - command decode and counter helpers for data_mem
`include "sys_defs.vh"

package data_mem_pkg;

    localparam int          DATA_W  = 32;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOAD,
        OP_STORE
    } op_e;

    // Unknown bus codes collapse to OP_NONE so they behave exactly like an idle cycle.
    function automatic op_e decode_op(input logic [1:0] cmd);
        case (cmd)
            `BUS_LOAD:  return OP_LOAD;
            `BUS_STORE: return OP_STORE;
            default:    return OP_NONE;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// rtl/dmem_store_buf.sv - one-entry store buffer with forwarding and opportunistic drain
`include "sys_defs.vh"

module dmem_store_buf
    import data_mem_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_en,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] din,
    output logic              fwd,
    output logic              wr_en,
    output logic [IDX_W-1:0]  sb_idx,
    output logic [DATA_W-1:0] sb_data
);

    logic sb_vld;
    logic hit;

    assign hit = sb_vld && (sb_idx == idx);
    assign fwd = ld_en && hit;

    // The array port is free only when no load is reading it; a store to the
    // same word just merges into the entry.
    assign wr_en = sb_vld && (st_en ? !hit : !ld_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_vld  <= `FALSE;
            sb_idx  <= '0;
            sb_data <= '0;
        end else if (st_en) begin
            sb_vld  <= `TRUE;
            sb_idx  <= idx;
            sb_data <= din;
        end else if (!ld_en) begin
            sb_vld  <= `FALSE;
        end
    end

endmodule

// File: rtl/sys_defs.vh
// rtl/sys_defs.vh - shared processor bus command codes and boolean literals
`ifndef SYS_DEFS_VH
`define SYS_DEFS_VH

`define FALSE     1'h0
`define TRUE      1'h1

`define BUS_NONE  2'h0
`define BUS_LOAD  2'h1
`define BUS_STORE 2'h2

`endif

// File: rtl/data_mem.sv
// rtl/data_mem.sv - single-port data memory with zero-latency loads and a store buffer
// Optional statistics counters enabled by defining DMEM_STATS_EN.
`include "sys_defs.vh"

module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MEM_mem_addr,
    input  logic [1:0]  MEM_mem_cmd,
    input  logic [31:0] MEM_mem_din,
    output logic [31:0] DM_mem_dout,
    output logic        DM_err,
    output logic [31:0] DM_ld_cnt,
    output logic [31:0] DM_st_cnt,
    output logic [31:0] DM_fwd_cnt
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    op_e              op;
    logic [IDX_W-1:0] idx;
    logic             legal;
    logic             ld_ok;
    logic             st_ok;
    logic             fwd;
    logic             wr_en;
    logic [IDX_W-1:0] sb_idx;
    logic [31:0]      sb_data;
    logic [31:0]      mem [DEPTH_WORDS];

    assign op    = decode_op(MEM_mem_cmd);
    assign idx   = MEM_mem_addr[IDX_W+1:2];
    assign legal = (MEM_mem_addr[1:0] == 2'b00) && (MEM_mem_addr[31:IDX_W+2] == '0);

    // Qualifying with rst_n keeps dout/err quiet while reset is held.
    assign ld_ok  = rst_n && (op == OP_LOAD) && legal;
    assign st_ok  = rst_n && (op == OP_STORE) && legal;
    assign DM_err = rst_n && (op != OP_NONE) && !legal;

    assign DM_mem_dout = !ld_ok ? 32'h0 : (fwd ? sb_data : mem[idx]);

    dmem_store_buf #(
        .IDX_W (IDX_W)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .st_en   (st_ok),
        .ld_en   (ld_ok),
        .idx     (idx),
        .din     (MEM_mem_din),
        .fwd     (fwd),
        .wr_en   (wr_en),
        .sb_idx  (sb_idx),
        .sb_data (sb_data)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[sb_idx] <= sb_data;
        end
    end

`ifdef DMEM_STATS_EN
    logic [31:0] ld_cnt;
    logic [31:0] st_cnt;
    logic [31:0] fwd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            st_cnt  <= '0;
            fwd_cnt <= '0;
        end else begin
            if (ld_ok) ld_cnt  <= sat_inc(ld_cnt);
            if (st_ok) st_cnt  <= sat_inc(st_cnt);
            if (fwd)   fwd_cnt <= sat_inc(fwd_cnt);
        end
    end

    assign DM_ld_cnt  = ld_cnt;
    assign DM_st_cnt  = st_cnt;
    assign DM_fwd_cnt = fwd_cnt;
`else
    assign DM_ld_cnt  = 32'h0;
    assign DM_st_cnt  = 32'h0;
    assign DM_fwd_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem against an architectural memory model
module tb_data_mem;

    localparam logic [1:0] C_NONE  = 2'h0;
    localparam logic [1:0] C_LOAD  = 2'h1;
    localparam logic [1:0] C_STORE = 2'h2;
    localparam int         WORDS   = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] MEM_mem_addr = '0;
    logic [1:0]  MEM_mem_cmd = C_NONE;
    logic [31:0] MEM_mem_din = '0;
    logic [31:0] DM_mem_dout;
    logic        DM_err;
    logic [31:0] DM_ld_cnt;
    logic [31:0] DM_st_cnt;
    logic [31:0] DM_fwd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: drained words plus the one store not yet committed.
    logic [31:0] arr [WORDS];
    bit          pend;
    int unsigned pidx;
    logic [31:0] pdata;
    logic [31:0] m_ld, m_st, m_fwd;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vt [15];

    data_mem #(.DEPTH_WORDS(WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MEM_mem_addr (MEM_mem_addr),
        .MEM_mem_cmd  (MEM_mem_cmd),
        .MEM_mem_din  (MEM_mem_din),
        .DM_mem_dout  (DM_mem_dout),
        .DM_err       (DM_err),
        .DM_ld_cnt    (DM_ld_cnt),
        .DM_st_cnt    (DM_st_cnt),
        .DM_fwd_cnt   (DM_fwd_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stat(input logic [31:0] v);
`ifdef DMEM_STATS_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic check_cnts(input string tag);
        check({tag, " ld_cnt"},  DM_ld_cnt,  stat(m_ld));
        check({tag, " st_cnt"},  DM_st_cnt,  stat(m_st));
        check({tag, " fwd_cnt"}, DM_fwd_cnt, stat(m_fwd));
    endtask

    // One bus cycle: drive at negedge, compare combinational outputs, then advance the model.
    task automatic cyc(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] got_d, output logic got_e);
        bit          leg, isld, isst;
        int unsigned w;
        logic [31:0] ed;
        logic        ee;
        @(negedge clk);
        MEM_mem_cmd  = c;
        MEM_mem_addr = a;
        MEM_mem_din  = d;
        #2;
        leg  = (a < 32'h1000) && (a % 4 == 0);
        w    = a / 4;
        isld = (c == C_LOAD) && leg;
        isst = (c == C_STORE) && leg;
        ee   = ((c == C_LOAD) || (c == C_STORE)) && !leg;
        ed   = 32'h0;
        if (isld) ed = (pend && pidx == w) ? pdata : arr[w];
        check("dout", DM_mem_dout, ed);
        check("err", {31'h0, DM_err}, {31'h0, ee});
        got_d = DM_mem_dout;
        got_e = DM_err;
        @(posedge clk);
        if (isst) begin
            if (pend && pidx != w) arr[pidx] = pdata;
            pend = 1; pidx = w; pdata = d;
            m_st = m_st + 1;
        end else if (isld) begin
            m_ld = m_ld + 1;
            if (pend && pidx == w) m_fwd = m_fwd + 1;
        end else if (pend) begin
            arr[pidx] = pdata;
            pend = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        MEM_mem_cmd  = C_LOAD;
        MEM_mem_addr = 32'h40;
        #1;
        check("rst dout", DM_mem_dout, 32'h0);
        check("rst err", {31'h0, DM_err}, 32'h0);
        MEM_mem_addr = 32'h42;
        #1;
        check("rst err illegal", {31'h0, DM_err}, 32'h0);
        check("rst sb_vld", {31'h0, dut.u_sb.sb_vld}, 32'h0);
        pend = 0; m_ld = 0; m_st = 0; m_fwd = 0;
        check_cnts("rst");
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        MEM_mem_cmd = C_NONE;
    endtask

    initial begin
        logic [31:0] gd;
        logic        ge;
        logic [1:0]  rc;
        logic [31:0] ra;
        int unsigned sel;

        vt[0]  = '{C_STORE, 32'h40,   32'hDEAD_BEEF, 32'h0,         1'b0};
        vt[1]  = '{C_LOAD,  32'h40,   32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[2]  = '{C_STORE, 32'h40,   32'h1,         32'h0,         1'b0};
        vt[3]  = '{C_STORE, 32'h44,   32'h2,         32'h0,         1'b0};
        vt[4]  = '{C_NONE,  32'h40,   32'h0,         32'h0,         1'b0};
        vt[5]  = '{C_NONE,  32'h44,   32'h0,         32'h0,         1'b0};
        vt[6]  = '{C_LOAD,  32'h40,   32'h0,         32'h1,         1'b0};
        vt[7]  = '{C_LOAD,  32'h44,   32'h0,         32'h2,         1'b0};
        vt[8]  = '{C_LOAD,  32'h42,   32'h0,         32'h0,         1'b1};
        vt[9]  = '{C_STORE, 32'h1000, 32'h77,        32'h0,         1'b1};
        vt[10] = '{C_LOAD,  32'h44,   32'h0,         32'h2,         1'b0};
        vt[11] = '{2'h3,    32'h44,   32'h0,         32'h0,         1'b0};
        vt[12] = '{C_LOAD,  32'h1004, 32'h0,         32'h0,         1'b1};
        vt[13] = '{C_LOAD,  32'hFFC,  32'h0,         32'hC0DE_03FF, 1'b0};
        vt[14] = '{C_LOAD,  32'h3,    32'h0,         32'h0,         1'b1};

        pend = 0; pidx = 0; pdata = 0; m_ld = 0; m_st = 0; m_fwd = 0;

        do_reset();

        for (int i = 0; i < WORDS; i++)
            cyc(C_STORE, i * 4, 32'hC0DE_0000 | i, gd, ge);
        cyc(C_NONE, 32'h0, 32'h0, gd, ge);
        check("init drained sb_vld", {31'h0, dut.u_sb.sb_vld}, 32'h0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].cmd, vt[i].addr, vt[i].din, gd, ge);
            check($sformatf("vec%0d dout", i), gd, vt[i].exp_dout);
            check($sformatf("vec%0d err", i), {31'h0, ge}, {31'h0, vt[i].exp_err});
        end
        check("tbl ld_cnt",  DM_ld_cnt,  stat(32'd5));
        check("tbl st_cnt",  DM_st_cnt,  stat(32'd3));
        check("tbl fwd_cnt", DM_fwd_cnt, stat(32'd1));

        // Two stores then two idle cycles must leave nothing buffered.
        cyc(C_STORE, 32'h40, 32'h1, gd, ge);
        cyc(C_STORE, 32'h44, 32'h2, gd, ge);
        check("seq2 sb_vld busy", {31'h0, dut.u_sb.sb_vld}, 32'h1);
        cyc(C_NONE, 32'h0, 32'h0, gd, ge);
        cyc(C_NONE, 32'h0, 32'h0, gd, ge);
        check("seq2 sb_vld idle", {31'h0, dut.u_sb.sb_vld}, 32'h0);
        cyc(C_LOAD, 32'h40, 32'h0, gd, ge);
        check("seq2 ld40", gd, 32'h1);
        cyc(C_LOAD, 32'h44, 32'h0, gd, ge);
        check("seq2 ld44", gd, 32'h2);

        // Same-word back-to-back stores merge in the buffer.
        cyc(C_STORE, 32'h80, 32'hA, gd, ge);
        cyc(C_STORE, 32'h80, 32'hB, gd, ge);
        check("seq3 array untouched", dut.mem[32], 32'hC0DE_0020);
        cyc(C_LOAD, 32'h80, 32'h0, gd, ge);
        check("seq3 ld80", gd, 32'hB);

        // A buffered store is lost across reset.
        cyc(C_STORE, 32'h40, 32'h5, gd, ge);
        do_reset();
        cyc(C_LOAD, 32'h40, 32'h0, gd, ge);
        check("seq4 ld40 after reset", gd, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            rc  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            ra  = $urandom_range(0, 15) * 4;
            if (sel == 0)      ra = ra | $urandom_range(1, 3);
            else if (sel == 1) ra = ra | (32'h1 << $urandom_range(12, 31));
            cyc(rc, ra, $urandom, gd, ge);
        end
        check_cnts("random");

        do_reset();
        for (int i = 0; i < 100; i++)
            cyc(C_LOAD, $urandom_range(0, WORDS - 1) * 4, 32'h0, gd, ge);
        check("100 loads ld_cnt", DM_ld_cnt, stat(32'd100));
        check("100 loads st_cnt", DM_st_cnt, 32'h0);
        check_cnts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
